// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte open-drain I2C master.
// START, address+R/W, one data byte, ACK handling and STOP.
module i2c_master_ctrl #(
  parameter int ADDRESSLENGTH = 7,
  parameter int CLKDIV = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     Start,
  input  logic                     RorW,
  input  logic [ADDRESSLENGTH-1:0] SlaveAddress,
  input  logic [7:0]               WriteData,
  input  logic                     SDA_IN,
  output logic                     SCL,
  output logic                     SDA,
  output logic [7:0]               ReadData,
  output logic                     Busy,
  output logic                     Done,
  output logic                     AckError
);
  localparam int QW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(CLKDIV - 1);
  localparam logic [7:0] ALAST = 8'(ADDRESSLENGTH);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA,
    S_WDATA_ACK, S_RDATA, S_RDATA_NACK, S_STOP
  } state_t;

  state_t                 state;
  logic [QW-1:0]          qc;
  logic [1:0]             ph;
  logic [7:0]             bc;
  logic [ADDRESSLENGTH:0] frame;
  logic [7:0]             dat;
  logic                   rw;
  logic                   samp;
  logic                   tick;
  logic                   slot_end;
  logic                   accept;

  assign tick     = (qc == QMAX);
  assign slot_end = (state != S_IDLE) && tick && (ph == 2'd3);
  // STOP end with Start held chains straight into the next START
  assign accept   = Start &&
                    ((state == S_IDLE) ||
                     ((state == S_STOP) && slot_end));

  always_comb begin
    SCL = 1'b1;
    SDA = 1'b1;
    unique case (state)
      S_START: SDA = ~ph[1];
      S_ADDR: begin
        SCL = ph[1];
        SDA = frame[ADDRESSLENGTH];
      end
      S_WDATA: begin
        SCL = ph[1];
        SDA = dat[7];
      end
      S_ADDR_ACK, S_WDATA_ACK,
      S_RDATA, S_RDATA_NACK: SCL = ph[1];
      S_STOP: begin
        SCL = ph[1];
        SDA = (ph == 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      qc       <= '0;
      ph       <= '0;
      bc       <= '0;
      frame    <= '0;
      dat      <= '0;
      rw       <= 1'b0;
      samp     <= 1'b1;
      ReadData <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      AckError <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (state != S_IDLE) begin
        qc <= tick ? '0 : qc + 1'b1;
        if (tick) ph <= ph + 2'd1;
        if (tick && ph == 2'd2) begin
          samp <= SDA_IN;
          if (state == S_RDATA) dat <= {dat[6:0], SDA_IN};
        end
      end
      if (slot_end) begin
        unique case (state)
          S_START: begin
            state <= S_ADDR;
            bc    <= '0;
          end
          S_ADDR: begin
            frame <= frame << 1;
            if (bc == ALAST) begin
              state <= S_ADDR_ACK;
              bc    <= '0;
            end else begin
              bc <= bc + 8'd1;
            end
          end
          S_ADDR_ACK: begin
            bc <= '0;
            if (samp) begin
              AckError <= 1'b1;
              state    <= S_STOP;
            end else begin
              state <= rw ? S_RDATA : S_WDATA;
            end
          end
          S_WDATA: begin
            dat <= {dat[6:0], 1'b0};
            if (bc == 8'd7) begin
              state <= S_WDATA_ACK;
              bc    <= '0;
            end else begin
              bc <= bc + 8'd1;
            end
          end
          S_WDATA_ACK: begin
            if (samp) AckError <= 1'b1;
            state <= S_STOP;
          end
          S_RDATA: begin
            if (bc == 8'd7) begin
              ReadData <= dat;
              state    <= S_RDATA_NACK;
              bc       <= '0;
            end else begin
              bc <= bc + 8'd1;
            end
          end
          S_RDATA_NACK: state <= S_STOP;
          S_STOP: begin
            state <= S_IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
          default: ;
        endcase
      end
      if (accept) begin
        state    <= S_START;
        qc       <= '0;
        ph       <= '0;
        bc       <= '0;
        frame    <= {SlaveAddress, RorW};
        dat      <= WriteData;
        rw       <= RorW;
        Busy     <= 1'b1;
        AckError <= 1'b0;
      end
    end
  end
endmodule
